// File: rtl/serial_ripple_adder.sv
// Bit-serial ripple-carry adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_RIPPLE_ADDER_OVF_EN.
module serial_ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             s_bit;
    logic             c_nxt;
    logic             last_bit;

    assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign last_bit = (state_q == RUN) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            RUN: begin
                res_d = {s_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_nxt;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    // Publish only the completed word so sum never shows partial bits.
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
                    state_d = DONE;
                end
            end
            default: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_RIPPLE_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // On the MSB edge c_q is the carry into the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (last_bit) begin
            ovf_d = c_q ^ c_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Signed-overflow flag not built in this configuration.
`endif

endmodule
